// File: rtl/narnet_engine_if.sv
// Handshake and memory-port bundle for the NAR-network inference engine.
// The engine connects through the slave modport; the parent (sample source,
// result sink, weight memory and tanh table) connects through the master modport.
interface narnet_engine_if #(
   parameter int N  = 16,
   parameter int AW = 10
);

   logic signed [N-1:0]  x_in;
   logic                 x_valid;
   logic                 x_ready;
   logic                 closed_loop;
   logic                 flush;
   logic [AW-1:0]        w_addr;
   logic signed [N-1:0]  w_data;
   logic [N-1:0]         t_addr;
   logic signed [N-1:0]  t_data;
   logic signed [N-1:0]  y_out;
   logic                 out_valid;
   logic                 out_ready;

   modport slave (
      input  x_in, x_valid, closed_loop, flush, w_data, t_data, out_ready,
      output x_ready, w_addr, t_addr, y_out, out_valid
   );

   modport master (
      output x_in, x_valid, closed_loop, flush, w_data, t_data, out_ready,
      input  x_ready, w_addr, t_addr, y_out, out_valid
   );

endinterface

// File: rtl/narnet_engine.sv
// NAR-network inference engine: D-tap autoregressive delay line, H tanh hidden
// neurons and one linear output neuron, all evaluated on a single shared MAC.
// Weights and the tanh table live in parent-owned memories with 1-cycle reads,
// so every address is issued one cycle before its data is consumed.
module narnet_engine #(
   parameter int N    = 16,
   parameter int Q    = 10,
   parameter int D    = 16,
   parameter int H    = 5,
   parameter int G    = 8,
   parameter int INIT = 384,
   parameter int AW   = 10
) (
   input  logic            clk,
   input  logic            rst,
   narnet_engine_if.slave  bus
);

   localparam int AccW = N + G;
   localparam int PW   = $clog2(D);
   localparam int HIW  = (H > 1) ? $clog2(H) : 1;

   localparam logic [7:0]            LastL1     = 8'(D + 1);
   localparam logic [7:0]            LastL2     = 8'(H + 1);
   localparam logic [7:0]            NumD       = 8'(D);
   localparam logic [7:0]            NumH       = 8'(H);
   localparam logic [PW-1:0]         LastTap    = PW'(D - 1);
   localparam logic [HIW-1:0]        LastNeuron = HIW'(H - 1);
   localparam logic [AW-1:0]         B2Addr     = AW'(H + H * D);
   localparam logic signed [N-1:0]   TapInit    = N'(INIT);
   localparam logic signed [AccW-1:0] AccMax    = {{(G + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic signed [AccW-1:0] AccMin    = {{(G + 1){1'b1}}, {(N - 1){1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD, L1, TANH, L2, OUT} state_t;

   state_t                  r_state;
   logic signed [N-1:0]     r_taps [D];
   logic [PW-1:0]           r_head;
   logic [PW-1:0]           r_rdPtr;
   logic signed [N-1:0]     r_sample;
   logic signed [AccW-1:0]  r_acc;
   logic signed [N-1:0]     r_hidden [2**HIW];
   logic [HIW-1:0]          r_neuron;
   logic [HIW-1:0]          r_hidIdx;
   logic [7:0]              r_cnt;
   logic signed [N-1:0]     r_prevY;
   logic                    r_xReady;
   logic                    r_outValid;
   logic signed [N-1:0]     r_yOut;
   logic [AW-1:0]           r_wAddr;
   logic [N-1:0]            r_tAddr;

   logic signed [N-1:0]     w_mulOp;
   logic signed [2*N-1:0]   w_prod;
   logic signed [2*N-1:0]   w_prodShift;
   logic signed [AccW-1:0]  w_addend;
   logic signed [AccW-1:0]  w_bias;
   logic signed [AccW-1:0]  w_accNext;
   logic [PW-1:0]           w_headM1;

   // Clamp a wide accumulator value into the signed N-bit range.
   function automatic logic [N-1:0] satN(input logic signed [AccW-1:0] v);
      if (v > AccMax) begin
         return {1'b0, {(N - 1){1'b1}}};
      end else if (v < AccMin) begin
         return {1'b1, {(N - 1){1'b0}}};
      end else begin
         return v[N-1:0];
      end
   endfunction

   // MAC datapath: pick the operand paired with the returning weight, scale the product back to Q format and add.
   always_comb begin
      w_mulOp = r_taps[r_rdPtr];
      if (r_state == L2) begin
         w_mulOp = r_hidden[r_hidIdx];
      end
      w_prod      = (2 * N)'(bus.w_data) * (2 * N)'(w_mulOp);
      w_prodShift = w_prod >>> Q;
      w_addend    = AccW'(w_prodShift);
      w_bias      = AccW'(bus.w_data);
      w_accNext   = r_acc + w_addend;
      w_headM1    = (r_head == '0) ? LastTap : r_head - 1'b1;
   end

   // Sequencer: accepts samples, walks the hidden and output layers, and holds the result until it is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         for (int i = 0; i < D; i++) begin
            r_taps[i] <= TapInit;
         end
         for (int i = 0; i < 2**HIW; i++) begin
            r_hidden[i] <= '0;
         end
         r_head     <= '0;
         r_rdPtr    <= '0;
         r_sample   <= '0;
         r_acc      <= '0;
         r_neuron   <= '0;
         r_hidIdx   <= '0;
         r_cnt      <= '0;
         r_prevY    <= '0;
         r_xReady   <= 1'b1;
         r_outValid <= 1'b0;
         r_yOut     <= '0;
         r_wAddr    <= '0;
         r_tAddr    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_outValid && bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_xReady   <= 1'b1;
               end
               if (bus.flush) begin
                  for (int i = 0; i < D; i++) begin
                     r_taps[i] <= TapInit;
                  end
               end else if (bus.x_valid && r_xReady) begin
                  r_sample <= bus.closed_loop ? r_prevY : bus.x_in;
                  r_xReady <= 1'b0;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               r_taps[w_headM1] <= r_sample;
               r_head   <= w_headM1;
               r_rdPtr  <= w_headM1;
               r_neuron <= '0;
               r_cnt    <= '0;
               r_wAddr  <= '0;
               r_state  <= L1;
            end
            L1: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt < NumD) begin
                  r_wAddr <= AW'(H + int'(r_neuron) * D + int'(r_cnt));
               end
               if (r_cnt == 8'd1) begin
                  r_acc <= w_bias;
               end else if (r_cnt >= 8'd2) begin
                  r_acc   <= w_accNext;
                  r_rdPtr <= (r_rdPtr == LastTap) ? '0 : r_rdPtr + 1'b1;
               end
               if (r_cnt == LastL1) begin
                  r_tAddr <= satN(w_accNext);
                  r_cnt   <= '0;
                  r_state <= TANH;
               end
            end
            TANH: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == 8'd1) begin
                  r_hidden[r_neuron] <= bus.t_data;
                  r_cnt   <= '0;
                  r_rdPtr <= r_head;
                  if (r_neuron == LastNeuron) begin
                     r_wAddr  <= B2Addr;
                     r_hidIdx <= '0;
                     r_state  <= L2;
                  end else begin
                     r_wAddr  <= AW'(int'(r_neuron) + 1);
                     r_neuron <= r_neuron + 1'b1;
                     r_state  <= L1;
                  end
               end
            end
            L2: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt < NumH) begin
                  r_wAddr <= AW'(H + H * D + 1 + int'(r_cnt));
               end
               if (r_cnt == 8'd1) begin
                  r_acc <= w_bias;
               end else if (r_cnt >= 8'd2) begin
                  r_acc    <= w_accNext;
                  r_hidIdx <= r_hidIdx + 1'b1;
               end
               if (r_cnt == LastL2) begin
                  r_cnt   <= '0;
                  r_state <= OUT;
               end
            end
            OUT: begin
               r_yOut     <= satN(r_acc);
               r_prevY    <= satN(r_acc);
               r_outValid <= 1'b1;
               r_state    <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.x_ready   = r_xReady;
   assign bus.out_valid = r_outValid;
   assign bus.y_out     = r_yOut;
   assign bus.w_addr    = r_wAddr;
   assign bus.t_addr    = r_tAddr;

endmodule

// File: tb/tb_narnet_engine.sv
// Self-checking bench for narnet_engine: directed network cases plus randomized
// traffic, all compared against a plain-arithmetic reference of the network.
module tb_narnet_engine;

   localparam int N    = 16;
   localparam int Q    = 10;
   localparam int D    = 16;
   localparam int H    = 5;
   localparam int G    = 8;
   localparam int INIT = 384;
   localparam int AW   = 10;
   localparam int LAT  = 1 + H * (D + 4) + (H + 2) + 1;

   logic clk = 1'b0;
   logic rst;

   narnet_engine_if #(.N(N), .AW(AW)) bus ();

   narnet_engine #(
      .N(N), .Q(Q), .D(D), .H(H), .G(G), .INIT(INIT), .AW(AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int testCount = 0;
   int failCount = 0;

   logic signed [N-1:0] wmem [0:(1<<AW)-1];
   int                  tanhMode;
   int                  modelTaps [$];
   longint              prevY;
   longint              lastY;

   // Free-running clock.
   always #5 clk = ~clk;

   // Table lookup used as the tanh LUT: identity, or a hard clamp to +/-1.0.
   function automatic longint lutModel(input logic [N-1:0] a);
      longint v;
      v = longint'($signed(a));
      if (tanhMode == 1) begin
         if (v > 1024) v = 1024;
         if (v < -1024) v = -1024;
      end
      return v;
   endfunction

   // Parent-side memories with one cycle of read latency.
   always @(posedge clk) begin
      bus.w_data <= wmem[bus.w_addr];
      bus.t_data <= N'(lutModel(bus.t_addr));
   end

   // Safety net so a hung engine never stalls the run.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, limit 2000000");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      testCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic longint wrapAcc(input longint v);
      longint m;
      m = v & ((longint'(1) << (N + G)) - 1);
      if (m >= (longint'(1) << (N + G - 1))) m = m - (longint'(1) << (N + G));
      return m;
   endfunction

   function automatic longint satv(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint predict();
      longint acc;
      longint hid [H];
      for (int h = 0; h < H; h++) begin
         acc = wrapAcc(longint'(wmem[h]));
         for (int d = 0; d < D; d++) begin
            acc = wrapAcc(acc + ((longint'(wmem[H + h * D + d]) * longint'(modelTaps[d])) >>> Q));
         end
         hid[h] = lutModel(N'(satv(acc)));
      end
      acc = wrapAcc(longint'(wmem[H + H * D]));
      for (int h = 0; h < H; h++) begin
         acc = wrapAcc(acc + ((longint'(wmem[H + H * D + 1 + h]) * hid[h]) >>> Q));
      end
      return satv(acc);
   endfunction

   task automatic modelFlush();
      modelTaps.delete();
      for (int i = 0; i < D; i++) modelTaps.push_back(INIT);
   endtask

   task automatic modelReset();
      modelFlush();
      prevY = 0;
   endtask

   task automatic clearWeights();
      for (int i = 0; i < (1 << AW); i++) wmem[i] = '0;
   endtask

   // Single-tap network: every neuron sees only tap dSel, the output sums all neurons.
   task automatic setNet(input int dSel, input int w1, input int w2);
      clearWeights();
      for (int h = 0; h < H; h++) begin
         wmem[H + h * D + dSel]    = N'(w1);
         wmem[H + H * D + 1 + h]   = N'(w2);
      end
   endtask

   task automatic doFlush(input bit collide);
      bus.flush = 1'b1;
      if (collide) begin
         bus.x_valid = 1'b1;
         bus.x_in    = 16'sd999;
      end
      @(posedge clk);
      @(negedge clk);
      bus.flush   = 1'b0;
      bus.x_valid = 1'b0;
      checkOutput("flush_x_ready", longint'(bus.x_ready), 1);
      modelFlush();
   endtask

   // One full transaction: accept, wait for the result, hold it, then drain.
   task automatic applyStimulus(input int sample, input bit closed, input int hold, input bit noise);
      int     waited;
      int     cnt;
      longint expY;
      waited = 0;
      while (!bus.x_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_x_ready", longint'(bus.x_ready), 1);
      bus.x_in        = N'(sample);
      bus.closed_loop = closed;
      bus.x_valid     = 1'b1;
      @(posedge clk);
      modelTaps.push_front(closed ? int'(prevY) : sample);
      void'(modelTaps.pop_back());
      expY = predict();
      @(negedge clk);
      bus.x_valid     = 1'b0;
      bus.closed_loop = 1'b0;
      cnt = 0;
      while (cnt < 500) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (bus.out_valid) break;
         if (noise) begin
            bus.x_valid = 1'($urandom_range(0, 1));
            bus.x_in    = N'($urandom);
            bus.flush   = ($urandom_range(0, 7) == 0);
         end
      end
      bus.x_valid = 1'b0;
      bus.flush   = 1'b0;
      checkOutput("latency", longint'(cnt), LAT);
      lastY = longint'(bus.y_out);
      checkOutput("y_out", lastY, expY);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", longint'(bus.out_valid), 1);
         checkOutput("hold_y", longint'(bus.y_out), expY);
         checkOutput("hold_x_ready", longint'(bus.x_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("drain_valid", longint'(bus.out_valid), 0);
      checkOutput("drain_x_ready", longint'(bus.x_ready), 1);
      prevY = expY;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_x_ready"}, longint'(bus.x_ready), 1);
      checkOutput({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      checkOutput({tag, "_y_out"}, longint'(bus.y_out), 0);
      checkOutput({tag, "_w_addr"}, longint'(bus.w_addr), 0);
      checkOutput({tag, "_t_addr"}, longint'(bus.t_addr), 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetState("reset");
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      @(negedge clk);
   endtask

   // Directed network cases followed by randomized traffic.
   initial begin
      int v;
      rst             = 1'b0;
      bus.x_in        = '0;
      bus.x_valid     = 1'b0;
      bus.closed_loop = 1'b0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b0;
      tanhMode        = 0;
      lastY           = 0;
      clearWeights();
      modelReset();
      repeat (2) @(negedge clk);
      checkResetState("init");
      rst = 1'b1;
      @(negedge clk);

      // Only b2 set: output equals the bias, held while downstream stalls.
      wmem[H + H * D] = 16'sd1024;
      applyStimulus(0, 1'b0, 5, 1'b0);
      checkOutput("t1_bias_only", lastY, 1024);

      // Newest tap passes straight through each neuron.
      setNet(0, 1024, 1024);
      applyStimulus(512, 1'b0, 0, 1'b0);
      checkOutput("t2_identity", lastY, 2560);

      // Oldest tap only: INIT values until the line has filled.
      doReset();
      setNet(D - 1, 1024, 1024);
      for (int k = 0; k < D; k++) begin
         applyStimulus(100, 1'b0, 0, 1'b0);
         checkOutput("t3_oldest", lastY, (k < D - 1) ? 1920 : 500);
      end
      doFlush(1'b0);
      applyStimulus(100, 1'b0, 0, 1'b0);
      checkOutput("t3_after_flush", lastY, 1920);

      // Closed loop feeds the previous prediction back, ignoring x_in.
      setNet(0, 1024, 1024);
      applyStimulus(100, 1'b0, 0, 1'b0);
      checkOutput("t4_open", lastY, 500);
      applyStimulus(7, 1'b1, 0, 1'b0);
      checkOutput("t4_closed", lastY, 2500);

      // Saturation in both directions.
      setNet(0, 32767, 32767);
      applyStimulus(32767, 1'b0, 0, 1'b0);
      checkOutput("t5_sat_pos", lastY, 32767);
      applyStimulus(-32768, 1'b0, 0, 1'b0);
      checkOutput("t5_sat_neg", lastY, -32768);

      // Flush and x_valid together: flush wins, sample dropped.
      setNet(D - 1, 1024, 1024);
      doFlush(1'b1);
      applyStimulus(100, 1'b0, 0, 1'b0);
      checkOutput("t6_flush_wins", lastY, 1920);

      // Reset while busy in the first hidden neuron.
      bus.x_in    = 16'sd100;
      bus.x_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.x_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetState("midrun");
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      @(negedge clk);
      checkOutput("midrun_no_output", longint'(bus.out_valid), 0);
      applyStimulus(100, 1'b0, 0, 1'b0);
      checkOutput("t7_after_reset", lastY, 1920);

      // Randomized weights, samples, flushes, feedback and stalls.
      tanhMode = 1;
      for (int i = 0; i < (1 << AW); i++) begin
         v = int'($urandom_range(0, 1023)) - 512;
         wmem[i] = N'(v);
      end
      for (int h = 0; h < H; h++) begin
         v = int'($urandom_range(0, 4095)) - 2048;
         wmem[h] = N'(v);
         v = int'($urandom_range(0, 4095)) - 2048;
         wmem[H + H * D + 1 + h] = N'(v);
      end
      v = int'($urandom_range(0, 4095)) - 2048;
      wmem[H + H * D] = N'(v);
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 5) == 0) begin
            doFlush(1'($urandom_range(0, 1)));
         end
         v = int'($urandom_range(0, 8191)) - 4096;
         applyStimulus(v, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
